// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide, one result bit per cycle.
// Optional build macro MULDIV_EARLY_OUT_EN lets divide-by-zero, signed overflow and multiply-by-zero skip CALC.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            zr
);
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [XLEN-1:0]     opnd_q, a_raw_q;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                neg_a_q, neg_res_q, div0_q, ovf_q, mulz_q;
  logic                busy_q, busy_d, done_q, done_d, zr_q, zr_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept_s, is_div_s, sgn_a_s, sgn_b_s, neg_a_s, neg_b_s;
  logic                div0_s, ovf_s, mulz_s, early_s;
  logic [XLEN-1:0]     abs_a_s, abs_b_s;
  logic [XLEN:0]       add_s, trial_s, diff_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     quot_s, rem_s, fix_s;

  // Accept decode: operand signedness, magnitudes and special-case detection
  always_comb begin
    accept_s = start && (state_q == S_IDLE);
    is_div_s = op[2];
    sgn_a_s  = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    sgn_b_s  = sgn_a_s && (op != OP_MULHSU);
    neg_a_s  = sgn_a_s && operand_a[XLEN-1];
    neg_b_s  = sgn_b_s && operand_b[XLEN-1];
    abs_a_s  = neg_a_s ? neg_x(operand_a) : operand_a;
    abs_b_s  = neg_b_s ? neg_x(operand_b) : operand_b;
    div0_s   = is_div_s && (operand_b == ZERO_X);
    ovf_s    = ((op == OP_DIV) || (op == OP_REM)) && (operand_a == MIN_X) && (operand_b == ONES_X);
    mulz_s   = !is_div_s && ((operand_a == ZERO_X) || (operand_b == ZERO_X));
`ifdef MULDIV_EARLY_OUT_EN
    early_s  = div0_s || ovf_s || mulz_s;
`else
    early_s  = 1'b0;
`endif
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = early_s ? S_FIX : S_CALC;
        else          state_d = S_IDLE;
      end
      S_CALC: begin
        if (cnt_q == CW'(XLEN-1)) state_d = S_FIX;
        else                      state_d = S_CALC;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Iteration step: shift-add for multiply, restoring subtract for divide
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    add_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    trial_s = acc_q[2*XLEN-1:XLEN-1];
    diff_s  = trial_s - {1'b0, opnd_q};
    if (accept_s) begin
      acc_d = {ZERO_X, (is_div_s ? abs_a_s : abs_b_s)};
      cnt_d = {CW{1'b0}};
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      if (!op_q[2])          acc_d = {add_s, acc_q[XLEN-1:1]};
      else if (!diff_s[XLEN]) acc_d = {diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                    acc_d = {trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Datapath registers: operands and flags latched on accept, accumulator every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= 3'b000;
      opnd_q    <= ZERO_X;
      a_raw_q   <= ZERO_X;
      neg_a_q   <= 1'b0;
      neg_res_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      mulz_q    <= 1'b0;
      acc_q     <= {(2*XLEN){1'b0}};
      cnt_q     <= {CW{1'b0}};
    end else begin
      if (accept_s) begin
        op_q      <= op;
        opnd_q    <= is_div_s ? abs_b_s : abs_a_s;
        a_raw_q   <= operand_a;
        neg_a_q   <= neg_a_s;
        neg_res_q <= neg_a_s ^ neg_b_s;
        div0_q    <= div0_s;
        ovf_q     <= ovf_s;
        mulz_q    <= mulz_s;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Final sign fix-up, result selection and special-case override
  always_comb begin
    prod_s = neg_res_q ? neg_2x(acc_q) : acc_q;
    quot_s = neg_res_q ? neg_x(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem_s  = neg_a_q ? neg_x(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
    fix_s  = ZERO_X;
    if (div0_q) begin
      fix_s = op_q[1] ? a_raw_q : ONES_X;
    end else if (ovf_q) begin
      fix_s = op_q[1] ? ZERO_X : MIN_X;
    end else if (mulz_q) begin
      fix_s = ZERO_X;
    end else begin
      case (op_q)
        OP_MUL:                       fix_s = prod_s[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fix_s = prod_s[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:              fix_s = quot_s;
        OP_REM, OP_REMU:              fix_s = rem_s;
        default:                      fix_s = ZERO_X;
      endcase
    end
  end

  // Output next-state: busy follows the FSM, result/zr/done update only from FIX
  always_comb begin
    busy_d = (state_d != S_IDLE);
    if (state_q == S_FIX) begin
      done_d   = 1'b1;
      result_d = fix_s;
      zr_d     = (fix_s == ZERO_X);
    end else begin
      done_d   = 1'b0;
      result_d = result_q;
      zr_d     = zr_q;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= ZERO_X;
      zr_q     <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zr_q     <= zr_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zr     = zr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations against an arithmetic model.
module tb_muldiv_unit;
  localparam int XLEN     = 32;
  localparam int LAT_FULL = XLEN + 1;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b, result;
  logic        busy, done, zr;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .result(result), .zr(zr)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed/unsigned arithmetic with the ISA corner rules
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p  = 64'h0;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    bit early;
    early = (o[2] && b == 32'h0)
         || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         || (!o[2] && (a == 32'h0 || b == 32'h0));
    return early ? 1 : LAT_FULL;
`else
    return LAT_FULL + 0 * int'({o, a, b} == 67'h0);
`endif
  endfunction

  // Called at the negedge k0 cycles after the accepting edge; waits for done with a bound.
  task automatic wait_done(input int k0, input int lat, input logic [31:0] exp, input string tag);
    int          k;
    logic [31:0] prev;
    bit          moved;
    k     = k0;
    prev  = result;
    moved = 1'b0;
    while (done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      if (done !== 1'b1 && result !== prev) moved = 1'b1;
    end
    check_eq({tag, " latency"}, 64'(k), 64'(lat));
    check_eq({tag, " early change"}, 64'(moved), 64'h0);
    check_eq({tag, " result"}, 64'(result), 64'(exp));
    check_eq({tag, " zr"}, 64'(zr), 64'(exp == 32'h0));
    check_eq({tag, " busy at done"}, 64'(busy), 64'h0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, " busy"}, 64'(busy), 64'h1);
    wait_done(0, ref_lat(o, a, b), exp, tag);
    @(negedge clk);
    check_eq({tag, " pulse"}, 64'(done), 64'h0);
    check_eq({tag, " hold"}, 64'(result), 64'(exp));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; op = 3'd0; operand_a = 32'h0; operand_b = 32'h0;
    #1;
    check_eq("reset busy", 64'(busy), 64'h0);
    check_eq("reset done", 64'(done), 64'h0);
    check_eq("reset result", 64'(result), 64'h0);
    check_eq("reset zr", 64'(zr), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'd0, 32'd2565, 32'd1560, 32'd4001400, "MUL");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, "MULH");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM");
    run_op(3'd5, 32'd2565, 32'd1560, 32'd1, "DIVU");
    run_op(3'd7, 32'd2565, 32'd1560, 32'd1005, "REMU");
    run_op(3'd5, 32'd1, 32'd0, 32'hFFFF_FFFF, "DIVU by 0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, "REMU by 0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "REM ovf");
    run_op(3'd0, 32'h0, 32'd77, 32'h0, "MUL zero");

    // start pulsed mid-operation must be ignored
    op = 3'd5; operand_a = 32'd2565; operand_b = 32'd1560; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    op = 3'd0; operand_a = 32'd7; operand_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, LAT_FULL, 32'd1, "ignore");
    @(negedge clk);
    check_eq("ignore pulse", 64'(done), 64'h0);

    // start held through the done cycle gives back-to-back acceptance
    op = 3'd0; operand_a = 32'd2565; operand_b = 32'd1560; start = 1'b1;
    @(posedge clk); @(negedge clk);
    op = 3'd5; operand_a = 32'd100; operand_b = 32'd7;
    wait_done(0, LAT_FULL, 32'd4001400, "b2b first");
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b accepted", 64'(busy), 64'h1);
    check_eq("b2b pulse", 64'(done), 64'h0);
    wait_done(0, LAT_FULL, 32'd14, "b2b second");
    @(negedge clk);

    // asynchronous reset in the middle of a divide
    op = 3'd4; operand_a = 32'hFFFF_FFF9; operand_b = 32'd2; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset busy", 64'(busy), 64'h0);
    check_eq("midreset done", 64'(done), 64'h0);
    check_eq("midreset result", 64'(result), 64'h0);
    check_eq("midreset zr", 64'(zr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post reset idle", 64'(busy), 64'h0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, "MUL after reset");

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op(ro, ra, rb, ref_result(ro, ra, rb), $sformatf("rand%0d op%0d", i, ro));
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
